// File: rtl/pmp_lsu_gate.sv
// Load/store/fetch sequencer: registers a request, checks alignment, consults the
// PMP side-car, then issues one bus beat or returns a RISC-V fault with cause/tval.
module pmp_lsu_gate #(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_oper,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_priv,
    input  logic [31:0] req_wdata,
    output logic [31:0] pmp_addr,
    output logic [1:0]  pmp_oper,
    output logic [1:0]  pmp_priv_mode,
    output logic [1:0]  pmp_size,
    input  logic [1:0]  pmp_permission,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic        rsp_fault,
    output logic [3:0]  rsp_cause,
    output logic [31:0] rsp_tval,
    output logic [31:0] rsp_rdata
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;
    localparam logic [7:0] TMO      = 8'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_BUS, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  oper_q;
    logic [1:0]  size_q;
    logic [1:0]  priv_q;
    logic [7:0]  tmo_cnt;

    logic [1:0]  eff_size;
    logic        misaligned;
    logic        bad_size;
    logic        is_write;
    logic        tmo_hit;
    logic        active;
    logic        unused_region_match;

    function automatic logic [3:0] cause_of(input logic [1:0] op, input logic misal);
        case (op)
            OP_WRITE: cause_of = misal ? 4'd6 : 4'd7;
            OP_EXEC:  cause_of = misal ? 4'd0 : 4'd1;
            default:  cause_of = misal ? 4'd4 : 4'd5;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_enables = 4'b0001 << off;
            2'b01:   byte_enables = 4'b0011 << off;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (size)
            2'b00:   load_data = {24'd0, sh[7:0]};
            2'b01:   load_data = {16'd0, sh[15:0]};
            default: load_data = sh;
        endcase
    endfunction

    // Fetches are always word-sized regardless of the requested size.
    assign eff_size   = (req_oper == OP_EXEC) ? 2'b10 : req_size;
    assign misaligned = ((eff_size == 2'b01) && req_addr[0]) ||
                        ((eff_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign bad_size   = (eff_size == 2'b11);
    assign is_write   = (oper_q == OP_WRITE);
    assign tmo_hit    = ((tmo_cnt + 8'd1) == TMO);
    assign unused_region_match = pmp_permission[1];

    assign req_ready     = (state == S_IDLE);
    assign active        = (state != S_IDLE);
    assign pmp_addr      = active ? addr_q : 32'd0;
    assign pmp_oper      = active ? oper_q : 2'b00;
    assign pmp_priv_mode = active ? priv_q : 2'b00;
    assign pmp_size      = active ? size_q : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            oper_q    <= '0;
            size_q    <= '0;
            priv_q    <= '0;
            tmo_cnt   <= '0;
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_cause <= '0;
            rsp_tval  <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        oper_q  <= req_oper;
                        size_q  <= eff_size;
                        priv_q  <= req_priv;
                        if (bad_size || misaligned) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_cause <= cause_of(req_oper, misaligned);
                            rsp_tval  <= req_addr;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                end
                // pmp_* already reflect the latched request; verdict sampled here.
                S_CHECK: begin
                    if (pmp_permission[0]) begin
                        state     <= S_BUS;
                        tmo_cnt   <= '0;
                        bus_valid <= 1'b1;
                        bus_addr  <= {addr_q[31:2], 2'b00};
                        bus_we    <= is_write;
                        bus_be    <= byte_enables(size_q, addr_q[1:0]);
                        bus_wdata <= is_write ? replicate(size_q, wdata_q) : 32'd0;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_cause <= cause_of(oper_q, 1'b0);
                        rsp_tval  <= addr_q;
                    end
                end
                S_BUS: begin
                    if (tmo_hit) begin
                        bus_valid <= 1'b0;
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_cause <= cause_of(oper_q, 1'b0);
                        rsp_tval  <= addr_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (bus_ready) begin
                            bus_valid <= 1'b0;
                            if (is_write) begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                end
                // Timeout takes priority over a read return in the same cycle.
                S_WAIT: begin
                    if (tmo_hit) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_cause <= cause_of(oper_q, 1'b0);
                        rsp_tval  <= addr_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (bus_rvalid) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data(size_q, addr_q[1:0], bus_rdata);
                        end
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_cause <= '0;
                    rsp_tval  <= '0;
                    rsp_rdata <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_lsu_gate.sv
// Scoreboard bench for pmp_lsu_gate: requests push expected responses, a negedge
// monitor pops and compares them; a small bus model answers commands.
module tb_pmp_lsu_gate;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;

    logic        clock, reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_oper, req_size, req_priv;
    logic [31:0] pmp_addr;
    logic [1:0]  pmp_oper, pmp_priv_mode, pmp_size, pmp_permission;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        rsp_valid, rsp_fault;
    logic [3:0]  rsp_cause;
    logic [31:0] rsp_tval, rsp_rdata;

    pmp_lsu_gate #(.TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_oper(req_oper), .req_size(req_size), .req_priv(req_priv), .req_wdata(req_wdata),
        .pmp_addr(pmp_addr), .pmp_oper(pmp_oper), .pmp_priv_mode(pmp_priv_mode),
        .pmp_size(pmp_size), .pmp_permission(pmp_permission),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
        .rsp_tval(rsp_tval), .rsp_rdata(rsp_rdata)
    );

    typedef struct {
        int          cyc;
        logic        flt;
        logic [3:0]  cs;
        logic [31:0] tval;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [1:0]  oper;
        logic [1:0]  psize;
        logic [1:0]  priv;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Bus model knobs and captured command
    int          ready_delay = 0;
    int          rvalid_delay = 0;
    logic [31:0] rd_data = '0;
    bit          stray_rvalid = 0;
    bit          bus_seen = 0;
    int          stall = 0;
    bit          rd_pending = 0;
    int          rd_wait = 0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_we = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Response monitor
    always @(negedge clock) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.flt});
                if (e.flt) chk("rsp_cause", {28'd0, rsp_cause}, {28'd0, e.cs});
                chk("rsp_tval", rsp_tval, e.tval);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("pmp_addr", pmp_addr, e.addr);
                chk("pmp_oper", {30'd0, pmp_oper}, {30'd0, e.oper});
                chk("pmp_size", {30'd0, pmp_size}, {30'd0, e.psize});
                chk("pmp_priv", {30'd0, pmp_priv_mode}, {30'd0, e.priv});
            end
        end
    end

    // Bus model: ready after ready_delay stalled cycles, read data rvalid_delay cycles after accept
    initial begin
        bus_ready = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clock);
            bus_rvalid = 1'b0;
            if (bus_ready && !cap_we) begin
                rd_pending = 1;
                rd_wait = rvalid_delay;
            end
            if (stray_rvalid) begin
                bus_rvalid = 1'b1;
                bus_rdata = 32'hBAD0BAD0;
            end
            if (rd_pending) begin
                if (rd_wait == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata = rd_data;
                    rd_pending = 0;
                end else begin
                    rd_wait--;
                end
            end
            if (bus_valid) begin
                bus_seen = 1;
                if (stall >= ready_delay) begin
                    bus_ready = 1'b1;
                    cap_addr = bus_addr;
                    cap_we = bus_we;
                    cap_be = bus_be;
                    cap_wdata = bus_wdata;
                end else begin
                    bus_ready = 1'b0;
                    stall++;
                end
            end else begin
                bus_ready = 1'b0;
                stall = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] perm, input int lat,
                         input logic flt, input logic [3:0] cs, input logic [31:0] rd,
                         input bit expect_rsp);
        exp_t x;
        int   acc;
        bit   got;
        pmp_permission = perm;
        req_oper = op; req_size = sz; req_addr = a; req_wdata = wd; req_priv = 2'b01;
        req_valid = 1'b1;
        got = 0;
        acc = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (req_ready) begin got = 1; acc = cyc; end
        end
        if (!got) chk("req_ready_timeout", 32'd0, 32'd1);
        if (got && expect_rsp) begin
            x.cyc = acc + lat; x.flt = flt; x.cs = cs;
            x.tval = flt ? a : 32'd0; x.rdata = rd; x.addr = a; x.oper = op;
            x.psize = (op == OP_EXEC) ? 2'b10 : sz; x.priv = 2'b01;
            sb.push_back(x);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clock); #1;
        end
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_oper = '0; req_size = '0; req_priv = '0;
        req_wdata = '0; pmp_permission = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_pmp_addr", pmp_addr, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // read word
        rd_data = 32'hDEADBEEF;
        issue(OP_READ, 2'b10, 32'h20000000, 32'd0, 2'b01, 4, 1'b0, 4'd0, 32'hDEADBEEF, 1);
        drain();
        chk("rd_word_be", {28'd0, cap_be}, 32'h0000000F);
        chk("rd_word_addr", cap_addr, 32'h20000000);
        chk("rd_word_we", {31'd0, cap_we}, 32'd0);

        // write byte at lane 3
        issue(OP_WRITE, 2'b00, 32'h20000003, 32'h000000A5, 2'b01, 3, 1'b0, 4'd0, 32'd0, 1);
        drain();
        chk("wr_byte_be", {28'd0, cap_be}, 32'h00000008);
        chk("wr_byte_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("wr_byte_we", {31'd0, cap_we}, 32'd1);

        // misaligned store half
        bus_seen = 0;
        issue(OP_WRITE, 2'b01, 32'h20000001, 32'h00001234, 2'b01, 1, 1'b1, 4'd6, 32'd0, 1);
        drain();
        chk("misal_store_no_bus", {31'd0, bus_seen}, 32'd0);

        // fetch denied by pmp, size field ignored
        bus_seen = 0;
        issue(OP_EXEC, 2'b00, 32'h30000000, 32'd0, 2'b00, 2, 1'b1, 4'd1, 32'd0, 1);
        drain();
        chk("deny_exec_no_bus", {31'd0, bus_seen}, 32'd0);

        // read half upper lane, read byte lane 1
        issue(OP_READ, 2'b01, 32'h20000002, 32'd0, 2'b01, 4, 1'b0, 4'd0, 32'h0000DEAD, 1);
        drain();
        chk("rd_half_be", {28'd0, cap_be}, 32'h0000000C);
        issue(OP_READ, 2'b00, 32'h20000001, 32'd0, 2'b11, 4, 1'b0, 4'd0, 32'h000000BE, 1);
        drain();
        chk("rd_byte_be", {28'd0, cap_be}, 32'h00000002);

        // write half upper lane
        issue(OP_WRITE, 2'b01, 32'h20000002, 32'h00001234, 2'b01, 3, 1'b0, 4'd0, 32'd0, 1);
        drain();
        chk("wr_half_be", {28'd0, cap_be}, 32'h0000000C);
        chk("wr_half_wdata", cap_wdata, 32'h12341234);

        // reserved size, misaligned load word, misaligned fetch
        issue(OP_READ, 2'b11, 32'h20000000, 32'd0, 2'b01, 1, 1'b1, 4'd5, 32'd0, 1);
        issue(OP_READ, 2'b10, 32'h20000002, 32'd0, 2'b01, 1, 1'b1, 4'd4, 32'd0, 1);
        issue(OP_EXEC, 2'b00, 32'h30000002, 32'd0, 2'b01, 1, 1'b1, 4'd0, 32'd0, 1);
        drain();

        // permitted fetch
        rd_data = 32'h00000013;
        issue(OP_EXEC, 2'b00, 32'h30000004, 32'd0, 2'b01, 4, 1'b0, 4'd0, 32'h00000013, 1);
        drain();
        chk("exec_be", {28'd0, cap_be}, 32'h0000000F);

        // bus timeout: BUS entered at cycle 2, 15 cycles there, response at cycle 17
        ready_delay = 20;
        issue(OP_READ, 2'b01, 32'h2000000A, 32'd0, 2'b01, 17, 1'b1, 4'd5, 32'd0, 1);
        drain();
        ready_delay = 0;
        stray_rvalid = 1;
        @(posedge clock); #1;
        stray_rvalid = 0;
        repeat (3) @(posedge clock);
        #1;
        rd_data = 32'h11223344;
        issue(OP_READ, 2'b10, 32'h20000004, 32'd0, 2'b01, 4, 1'b0, 4'd0, 32'h11223344, 1);
        drain();

        // reset while waiting for read data
        rvalid_delay = 6;
        rd_data = 32'h55555555;
        issue(OP_READ, 2'b10, 32'h20000008, 32'd0, 2'b01, 4, 1'b0, 4'd0, 32'd0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_pmp_addr", pmp_addr, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        rvalid_delay = 0;
        rd_data = 32'hCAFEF00D;
        issue(OP_READ, 2'b10, 32'h20000008, 32'd0, 2'b01, 4, 1'b0, 4'd0, 32'hCAFEF00D, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
